// File: rtl/uart_tx.sv
// UART serial transmitter: one character per start edge, LSB first, optional parity,
// one or two stop bits, bit period chosen per frame from four divisors.
module uart_tx #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int BAUD_RATE_SEL_W = 2,
  parameter int TOTAL_CONF_W    = 5,
  parameter int BAUD_CNT_W      = 16,
  parameter int BAUD_DIV_0      = 10417,
  parameter int BAUD_DIV_1      = 5208,
  parameter int BAUD_DIV_2      = 1736,
  parameter int BAUD_DIV_3      = 868,
  parameter int PARITY_ODD      = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tx_en_i,
  input  logic                       tx_start_i,
  input  logic [TOTAL_CONF_W-1:0]    tx_conf_i,
  input  logic [BAUD_RATE_SEL_W-1:0] baud_sel_i,
  input  logic [MAX_UART_DATA_W-1:0] tx_data_i,
  output logic                       tx_o,
  output logic                       tx_busy_o,
  output logic                       tx_done_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [BAUD_CNT_W-1:0] sel_div(input logic [BAUD_RATE_SEL_W-1:0] sel);
    logic [BAUD_CNT_W-1:0] div;
    case (sel)
      BAUD_RATE_SEL_W'(0): div = BAUD_CNT_W'(BAUD_DIV_0);
      BAUD_RATE_SEL_W'(1): div = BAUD_CNT_W'(BAUD_DIV_1);
      BAUD_RATE_SEL_W'(2): div = BAUD_CNT_W'(BAUD_DIV_2);
      default:             div = BAUD_CNT_W'(BAUD_DIV_3);
    endcase
    return div;
  endfunction

  // Parity covers only the 5..8 bits actually transmitted.
  function automatic logic calc_parity(input logic [MAX_UART_DATA_W-1:0] data,
                                       input logic [1:0] len);
    logic p;
    p = (PARITY_ODD != 0);
    for (int i = 0; i < MAX_UART_DATA_W; i++) begin
      if (i < 5 + int'(len)) p = p ^ data[i];
    end
    return p;
  endfunction

  state_t                     state_q, state_d;
  logic                       start_prev_q, start_prev_d;
  logic [BAUD_CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic                       stop_idx_q, stop_idx_d;
  logic                       tx_q, tx_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [MAX_UART_DATA_W-1:0] data_q, data_d;
  logic [1:0]                 len_q, len_d;
  logic                       two_stop_q, two_stop_d;
  logic                       par_en_q, par_en_d;
  logic                       par_q, par_d;
  logic [BAUD_CNT_W-1:0]      div_q, div_d;
  logic [BAUD_CNT_W-1:0]      new_div;
  logic [2:0]                 nxt_idx;
  logic [2:0]                 last_idx;

  always_comb begin
    state_d      = state_q;
    start_prev_d = tx_start_i;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    data_d       = data_q;
    len_d        = len_q;
    two_stop_d   = two_stop_q;
    par_en_d     = par_en_q;
    par_d        = par_q;
    div_d        = div_q;
    new_div      = sel_div(baud_sel_i);
    nxt_idx      = bit_idx_q + 3'd1;
    last_idx     = 3'd4 + {1'b0, len_q};

    if (state_q == IDLE) begin
      tx_d   = 1'b1;
      busy_d = 1'b0;
      if (tx_en_i && tx_start_i && !start_prev_q) begin
        data_d     = tx_data_i;
        len_d      = tx_conf_i[4:3];
        two_stop_d = |tx_conf_i[2:1];
        par_en_d   = tx_conf_i[0];
        par_d      = calc_parity(tx_data_i, tx_conf_i[4:3]);
        div_d      = new_div;
        cnt_d      = new_div - BAUD_CNT_W'(1);
        state_d    = START;
        tx_d       = 1'b0;
        busy_d     = 1'b1;
      end
    end else if (!tx_en_i) begin
      state_d = IDLE;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - BAUD_CNT_W'(1);
    end else begin
      // Bit boundary: reload the timer and present the next bit.
      cnt_d = div_q - BAUD_CNT_W'(1);
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = data_q[0];
        end
        DATA: begin
          if (bit_idx_q == last_idx) begin
            stop_idx_d = 1'b0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = nxt_idx;
            tx_d      = data_q[nxt_idx];
          end
        end
        PARITY: begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
        default: begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Frame parameters captured at acceptance; only read while a frame is active.
  always_ff @(posedge clk_i) begin
    data_q     <= data_d;
    len_q      <= len_d;
    two_stop_q <= two_stop_d;
    par_en_q   <= par_en_d;
    par_q      <= par_d;
    div_q      <= div_d;
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected line bits are queued when a frame is
// launched and checked cycle by cycle as the DUT shifts them out.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst, tx_en, tx_start;
  logic [4:0] conf;
  logic [1:0] sel;
  logic [7:0] data;
  logic       tx, busy, done;
  logic       tx_odd, busy_odd, done_odd;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.BAUD_DIV_0(4), .BAUD_DIV_1(5), .BAUD_DIV_2(6), .BAUD_DIV_3(3),
            .PARITY_ODD(0)) dut (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .tx_start_i(tx_start),
    .tx_conf_i(conf), .baud_sel_i(sel), .tx_data_i(data),
    .tx_o(tx), .tx_busy_o(busy), .tx_done_o(done));

  uart_tx #(.BAUD_DIV_0(4), .BAUD_DIV_1(5), .BAUD_DIV_2(6), .BAUD_DIV_3(3),
            .PARITY_ODD(1)) dut_odd (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .tx_start_i(tx_start),
    .tx_conf_i(conf), .baud_sel_i(sel), .tx_data_i(data),
    .tx_o(tx_odd), .tx_busy_o(busy_odd), .tx_done_o(done_odd));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic [4:0] c, input bit odd);
    int   nd;
    logic p;
    nd = 5 + int'(c[4:3]);
    p  = odd;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (c[0]) exp_q.push_back(p);
    exp_q.push_back(1'b1);
    if (c[2:1] != 2'b00) exp_q.push_back(1'b1);
  endtask

  // Called at a negedge; the next posedge samples the start edge.
  task automatic start_frame(input logic [7:0] d, input logic [4:0] c,
                             input logic [1:0] s, input bit odd);
    data = d;
    conf = c;
    sel  = s;
    push_frame(d, c, odd);
    tx_start = 1'b1;
  endtask

  // With mid set, inputs are disturbed on the fifth cycle of the frame.
  task automatic check_frame(input int div, input bit odd, input bit mid);
    int   cyc;
    logic b;
    cyc = 0;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int j = 0; j < div; j++) begin
        @(negedge clk);
        chk("frame_tx",   odd ? tx_odd : tx, b);
        chk("frame_busy", odd ? busy_odd : busy, 1);
        chk("frame_done", odd ? done_odd : done, 0);
        cyc++;
        if (mid && cyc == 5) begin
          tx_start = 1'b0;
          sel      = 2'd0;
          data     = ~data;
          conf     = 5'b00_00_1;
        end
      end
    end
    @(negedge clk);
    chk("end_done", odd ? done_odd : done, 1);
    chk("end_busy", odd ? busy_odd : busy, 0);
    chk("end_tx",   odd ? tx_odd : tx, 1);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk({tag, "_tx"},   tx, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
    end
  endtask

  initial begin
    rst = 1'b1; tx_en = 1'b0; tx_start = 1'b0;
    conf = '0; sel = '0; data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_odd", tx_odd, 1);
    rst = 1'b0;
    tx_en = 1'b1;
    idle_cycles(2, "post_rst");

    // 8N1, 0xA5
    start_frame(8'hA5, 5'b11_00_0, 2'd0, 1'b0);
    check_frame(4, 1'b0, 1'b0);
    idle_cycles(2, "after_8n1");

    // baud/data/conf latch, then a zero-gap 7E2 frame launched in the done cycle
    tx_start = 1'b0;
    @(negedge clk);
    start_frame(8'h3C, 5'b11_00_0, 2'd3, 1'b0);
    check_frame(3, 1'b0, 1'b1);
    start_frame(8'h53, 5'b10_01_1, 2'd0, 1'b0);
    check_frame(4, 1'b0, 1'b0);
    idle_cycles(2, "after_7e2");

    // 5-bit odd parity with upper data bits set
    tx_start = 1'b0;
    @(negedge clk);
    start_frame(8'hFF, 5'b00_00_1, 2'd0, 1'b1);
    check_frame(4, 1'b1, 1'b0);

    // start left high: no repeat frame; a fresh edge sends one
    idle_cycles(6, "held_start");
    tx_start = 1'b0;
    @(negedge clk);
    start_frame(8'h0F, 5'b11_01_0, 2'd0, 1'b0);
    check_frame(4, 1'b0, 1'b0);
    idle_cycles(2, "after_8n2");

    // abort by dropping enable in DATA
    tx_start = 1'b0;
    @(negedge clk);
    tx_start = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    tx_en = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    idle_cycles(3, "after_abort");
    tx_en = 1'b1;
    idle_cycles(4, "en_with_start_high");

    // reset mid-frame, then a clean frame
    tx_start = 1'b0;
    @(negedge clk);
    tx_start = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tx_start = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    idle_cycles(2, "after_midrst");
    start_frame(8'h96, 5'b11_00_1, 2'd0, 1'b0);
    check_frame(4, 1'b0, 1'b0);
    idle_cycles(2, "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
